// File: rtl/pwm_deadtime_gen.sv
// Centre-aligned complementary PWM pair with dead-time insertion.
// Compare and dead-time values are double-buffered and switch over only at a triangle valley.
module pwm_deadtime_gen #(
  parameter int WIDTH    = 16,
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [WIDTH-1:0]    tri_q,
  input  logic [WIDTH-1:0]    cmp_in,
  input  logic [DT_WIDTH-1:0] dead_in,
  input  logic                cfg_wr,
  output logic                pwm_hi,
  output logic                pwm_lo,
  output logic                cycle_start,
  output logic                upd_pending
);

  // state   | meaning
  // ST_OFF  | disabled, both outputs low
  // ST_DEAD | dead-time gap, both outputs low, counting down to target side
  // ST_HI   | high-side driven
  // ST_LO   | low-side driven
  typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_HI, ST_LO} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    tri_prev_q;
  logic [WIDTH-1:0]    cmp_sh_q, cmp_sh_d, cmp_act_q, cmp_act_d;
  logic [DT_WIDTH-1:0] dead_sh_q, dead_sh_d, dead_act_q, dead_act_d;
  logic [DT_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                upd_pending_q, upd_pending_d;
  logic                raw_q, raw_d;
  logic                target_q, target_d;
  logic                cycle_start_q;
  logic                pwm_hi_q, pwm_hi_d, pwm_lo_q, pwm_lo_d;
  logic                valley, apply;

  always_comb begin
    valley        = (tri_q == '0) && (tri_prev_q != '0);
    apply         = valley && upd_pending_q;
    cmp_sh_d      = cmp_sh_q;
    dead_sh_d     = dead_sh_q;
    upd_pending_d = upd_pending_q;
    cmp_act_d     = cmp_act_q;
    dead_act_d    = dead_act_q;
    // Apply reads the shadow before a same-cycle write replaces it, so that write stays pending.
    if (apply) begin
      cmp_act_d     = cmp_sh_q;
      dead_act_d    = dead_sh_q;
      upd_pending_d = 1'b0;
    end
    if (cfg_wr) begin
      cmp_sh_d      = cmp_in;
      dead_sh_d     = dead_in;
      upd_pending_d = 1'b1;
    end
    raw_d = (tri_q < cmp_act_q);
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    target_d = target_q;
    if (!ena) begin
      state_d = ST_OFF;
      dcnt_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = ST_DEAD;
          dcnt_d   = dead_act_q;
          target_d = raw_q;
        end
        ST_HI: begin
          if (!raw_q) begin
            state_d  = ST_DEAD;
            dcnt_d   = dead_act_q;
            target_d = 1'b0;
          end
        end
        ST_LO: begin
          if (raw_q) begin
            state_d  = ST_DEAD;
            dcnt_d   = dead_act_q;
            target_d = 1'b1;
          end
        end
        ST_DEAD: begin
          // A compare flip during the gap restarts the full dead time toward the new side.
          if (raw_q != target_q) begin
            dcnt_d   = dead_act_q;
            target_d = raw_q;
          end else if (dcnt_q == '0) begin
            state_d = target_q ? ST_HI : ST_LO;
          end else begin
            dcnt_d = dcnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          dcnt_d  = '0;
        end
      endcase
    end
    pwm_hi_d = (state_d == ST_HI);
    pwm_lo_d = (state_d == ST_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_prev_q    <= '1;
      cmp_sh_q      <= '0;
      cmp_act_q     <= '0;
      dead_sh_q     <= '0;
      dead_act_q    <= '0;
      upd_pending_q <= 1'b0;
      raw_q         <= 1'b0;
      state_q       <= ST_OFF;
      dcnt_q        <= '0;
      target_q      <= 1'b0;
      cycle_start_q <= 1'b0;
      pwm_hi_q      <= 1'b0;
      pwm_lo_q      <= 1'b0;
    end else begin
      tri_prev_q    <= tri_q;
      cmp_sh_q      <= cmp_sh_d;
      cmp_act_q     <= cmp_act_d;
      dead_sh_q     <= dead_sh_d;
      dead_act_q    <= dead_act_d;
      upd_pending_q <= upd_pending_d;
      raw_q         <= raw_d;
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      target_q      <= target_d;
      cycle_start_q <= valley;
      pwm_hi_q      <= pwm_hi_d;
      pwm_lo_q      <= pwm_lo_d;
    end
  end

  assign pwm_hi      = pwm_hi_q;
  assign pwm_lo      = pwm_lo_q;
  assign cycle_start = cycle_start_q;
  assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen at WIDTH=4, DT_WIDTH=3 with hand-derived expected outputs,
// followed by a random run watching the complementary-output exclusion.
module tb_pwm_deadtime_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] tri_q;
  logic [3:0] cmp_in;
  logic [2:0] dead_in;
  logic       cfg_wr;
  logic       pwm_hi, pwm_lo, cycle_start, upd_pending;

  int n_chk  = 0;
  int n_pass = 0;
  int overlap = 0;

  pwm_deadtime_gen #(.WIDTH(4), .DT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tri_q(tri_q), .cmp_in(cmp_in),
    .dead_in(dead_in), .cfg_wr(cfg_wr), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
    .cycle_start(cycle_start), .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one tri_q value for one cycle, then compare {pwm_hi,pwm_lo}.
  task automatic step(input logic [3:0] t, input logic [1:0] exp, input string tag);
    tri_q = t;
    tick();
    chk(tag, {30'd0, pwm_hi, pwm_lo}, {30'd0, exp});
  endtask

  task automatic hold(input logic [3:0] t, input int n, input logic [1:0] exp, input string tag);
    tri_q = t;
    for (int i = 0; i < n; i++) tick();
    chk(tag, {30'd0, pwm_hi, pwm_lo}, {30'd0, exp});
  endtask

  task automatic write_cfg(input logic [3:0] t, input logic [3:0] c, input logic [2:0] d);
    tri_q = t; cmp_in = c; dead_in = d; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_wr = 1'b1; tri_q = 4'd0; cmp_in = 4'd5; dead_in = 3'd3;
    #23;
    chk("rst_outs", {28'd0, pwm_hi, pwm_lo, cycle_start, upd_pending}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; ena = 1'b0; cfg_wr = 1'b0;
    tick();
    chk("first_valley_cs", {31'd0, cycle_start}, 32'd1);
    chk("rst_pending", {31'd0, upd_pending}, 32'd0);
    tick();
    chk("cs_single", {31'd0, cycle_start}, 32'd0);
    tick(); tick();
    chk("cs_held_zero", {31'd0, cycle_start}, 32'd0);

    // Steady PWM: cmp 6, dead 2
    write_cfg(4'd0, 4'd6, 3'd2);
    chk("wr_pending", {31'd0, upd_pending}, 32'd1);
    tri_q = 4'd15; tick();
    tri_q = 4'd0;  tick();
    chk("apply_cs", {31'd0, cycle_start}, 32'd1);
    chk("apply_pending", {31'd0, upd_pending}, 32'd0);
    tri_q = 4'd1; tick();
    ena = 1'b1;
    step(4'd2, 2'b00, "en_dead0"); step(4'd3, 2'b00, "en_dead1"); step(4'd4, 2'b00, "en_dead2");
    step(4'd5, 2'b10, "first_hi"); step(4'd6, 2'b10, "hi_cross");
    step(4'd7, 2'b00, "h2l_dead0"); step(4'd8, 2'b00, "h2l_dead1"); step(4'd9, 2'b00, "h2l_dead2");
    step(4'd10, 2'b01, "first_lo");
    for (int t = 11; t <= 15; t++) step(4'(t), 2'b01, "lo_up");
    for (int t = 14; t >= 5; t--) step(4'(t), 2'b01, "lo_down");
    step(4'd4, 2'b00, "l2h_dead0"); step(4'd3, 2'b00, "l2h_dead1"); step(4'd2, 2'b00, "l2h_dead2");
    step(4'd1, 2'b10, "hi_again"); step(4'd0, 2'b10, "hi_valley");
    chk("sweep_cs", {31'd0, cycle_start}, 32'd1);

    // Write colliding with valley
    write_cfg(4'd0, 4'd3, 3'd0);
    chk("w3_pending", {31'd0, upd_pending}, 32'd1);
    tri_q = 4'd1; tick();
    tri_q = 4'd0; tick();
    chk("w3_applied", {31'd0, upd_pending}, 32'd0);
    write_cfg(4'd0, 4'd6, 3'd0);
    hold(4'd4, 5, 2'b01, "cmp3_probe4");
    tri_q = 4'd1; tick();
    write_cfg(4'd0, 4'd10, 3'd0);
    chk("collide_pending", {31'd0, upd_pending}, 32'd1);
    chk("collide_cs", {31'd0, cycle_start}, 32'd1);
    hold(4'd4, 5, 2'b10, "cmp6_probe4");
    hold(4'd8, 5, 2'b01, "cmp6_probe8");
    tri_q = 4'd1; tick();
    tri_q = 4'd0; tick();
    chk("cmp10_applied", {31'd0, upd_pending}, 32'd0);
    hold(4'd8, 5, 2'b10, "cmp10_probe8");

    // Boundary compares: cmp 0 then cmp 15, dead 1
    write_cfg(4'd8, 4'd0, 3'd1);
    tri_q = 4'd0; tick();
    hold(4'd0, 5, 2'b01, "cmp0_lo");
    for (int t = 1; t <= 15; t++) step(4'(t), 2'b01, "cmp0_up");
    for (int t = 14; t >= 0; t--) step(4'(t), 2'b01, "cmp0_down");
    write_cfg(4'd5, 4'd15, 3'd1);
    tri_q = 4'd0; tick();
    hold(4'd0, 5, 2'b10, "cmp15_hi");
    for (int t = 1; t <= 14; t++) step(4'(t), 2'b10, "cmp15_up");
    step(4'd15, 2'b10, "pk0"); step(4'd15, 2'b00, "pk_dead0"); step(4'd15, 2'b00, "pk_dead1");
    step(4'd15, 2'b01, "pk_lo0"); step(4'd15, 2'b01, "pk_lo1"); step(4'd14, 2'b01, "pk_lo2");
    step(4'd13, 2'b00, "pk_dead2"); step(4'd12, 2'b00, "pk_dead3");
    step(4'd11, 2'b10, "pk_hi"); step(4'd10, 2'b10, "pk_hi2");

    // Disable during HI and during DEAD
    ena = 1'b0; step(4'd10, 2'b00, "dis_hi");
    ena = 1'b1;
    step(4'd10, 2'b00, "reen_dead0"); step(4'd10, 2'b00, "reen_dead1"); step(4'd10, 2'b10, "reen_hi");
    step(4'd15, 2'b10, "to_dead_hi"); step(4'd15, 2'b00, "in_dead");
    ena = 1'b0; step(4'd15, 2'b00, "dis_dead"); step(4'd15, 2'b00, "off_hold");
    ena = 1'b1;
    step(4'd15, 2'b00, "reen2_dead0"); step(4'd15, 2'b00, "reen2_dead1"); step(4'd15, 2'b01, "reen2_lo");

    // Random stress with an asynchronous reset mid-run
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tri_q   = 4'($urandom_range(0, 15));
      cmp_in  = 4'($urandom_range(0, 15));
      dead_in = 3'($urandom_range(0, 7));
      cfg_wr  = ($urandom_range(0, 7) == 0);
      ena     = ($urandom_range(0, 15) != 0);
      if (cyc == 5000) begin
        ena = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {28'd0, pwm_hi, pwm_lo, cycle_start, upd_pending}, 32'd0);
        tick();
        rst_n = 1'b1;
      end
      tick();
      if (pwm_hi && pwm_lo) overlap++;
    end
    chk("no_overlap", overlap, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
Consumes the up/down triangle count from the upstream triangle counter. Produces a centre-aligned complementary PWM pair (pwm_hi / pwm_lo) with programmable dead time for the output driver stage. Compare and dead-time values are double-buffered: writes land in shadow registers and take effect only at a triangle valley, so updates are glitch-free.

Parameters:
WIDTH, 16, width of triangle count and compare value
DT_WIDTH, 8, width of dead-time value and dead-time counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  output enable; 0 forces both outputs low
tri_q  input  WIDTH  triangle count from upstream counter
cmp_in  input  WIDTH  new compare value
dead_in  input  DT_WIDTH  new dead time, in clk cycles
cfg_wr  input  1  1-cycle strobe; captures cmp_in and dead_in into shadow
pwm_hi  output  1  high-side drive
pwm_lo  output  1  low-side drive
cycle_start  output  1  1-cycle pulse at each detected valley
upd_pending  output  1  shadow written, not yet applied

Behaviour:
- Reset (rst_n=0, async): cmp_sh=cmp_act=0, dead_sh=dead_act=0, upd_pending=0, tri_prev=all ones, raw_r=0, state=OFF, dcnt=0, and pwm_hi, pwm_lo and cycle_start all 0.
- Valley detect: valley = (tri_q==0) && (tri_prev!=0). tri_prev is registered every cycle, regardless of ena. A counter held at 0 gives exactly one valley. Because tri_prev resets to all ones, a counter sitting at 0 immediately after reset still produces a valley.
- cycle_start is registered: valley seen in cycle n -> cycle_start=1 in cycle n+1.
- Shadow write: when cfg_wr=1, cmp_sh<=cmp_in, dead_sh<=dead_in, upd_pending<=1.
- Apply: when valley=1 and upd_pending=1, cmp_act<=cmp_sh, dead_act<=dead_sh, upd_pending<=0.
- Write in the same cycle as an apply: the apply uses the old shadow contents. The write then updates the shadow and upd_pending stays 1, so the new value applies at the next valley.
- Apply is not gated by ena.
- Compare: raw_r <= (tri_q < cmp_act), unsigned, registered.
  - cmp_act=0 -> raw_r is always 0 (100% low side).
  - cmp_act=all ones -> raw_r=0 only when tri_q=all ones.
- Output FSM states: OFF, DEAD, HI, LO. Outputs are registered.
  - HI: pwm_hi=1, pwm_lo=0.
  - LO: pwm_hi=0, pwm_lo=1.
  - OFF and DEAD: both outputs 0.
- FSM transitions:
  - ena=0 in any state -> next state OFF, dcnt=0. ena has priority over everything below.
  - OFF with ena=1 -> DEAD; dcnt<=dead_act; target<=raw_r.
  - HI or LO, when raw_r differs from the current side -> DEAD; dcnt<=dead_act; target<=raw_r.
  - DEAD with dcnt==0 -> target side (HI if target=1, else LO).
  - DEAD with dcnt!=0 -> dcnt<=dcnt-1.
  - raw_r changes while in DEAD -> target<=raw_r and dcnt reloads from dead_act (count restarts).
- Timing:
  - Dead time D means exactly D+1 cycles with both outputs low between sides.
  - With D=0, there is still 1 low cycle.
  - pwm_hi and pwm_lo are never 1 simultaneously, under any input sequence. This is a hard invariant.
- dead_act is sampled only at DEAD entry or reload. An apply mid-DEAD does not alter the running dcnt.
- Latency: tri_q crossing cmp_act in cycle n -> raw_r changes at n+1 -> state DEAD at n+2 -> new side asserted at n+3+D.

Test Plan:
1. Reset, WIDTH=4, DT_WIDTH=3.
   - Stimulus: rst_n=0, then release. Counter sits at 0.
   - Response: all outputs 0 during reset. cycle_start pulses once, 1 cycle after release. No further pulses while tri_q stays 0.
2. Steady PWM.
   - Stimulus: cfg_wr with cmp_in=6, dead_in=2; ena=1; tri_q sweeps 0..15..0.
   - Response: new values apply at the next valley; upd_pending drops the cycle after that valley. pwm_hi is high while raw_r is true (tri_q<6). Each transition shows exactly 3 cycles with both outputs low.
3. Write colliding with valley.
   - Stimulus: cfg_wr cmp_in=10 exactly in a valley cycle, with pending cmp_sh=6.
   - Response: cmp_act becomes 6 and upd_pending stays 1. cmp_act becomes 10 at the following valley.
4. Boundary compares.
   - Stimulus: cmp=0, then cmp=15.
   - Response: cmp=0 gives pwm_lo constant 1 after dead time. cmp=15 gives a low-side pulse only around tri_q=15, with dead gaps on both edges.
5. Mid-operation disable and re-enable.
   - Stimulus: ena dropped during HI, then during DEAD; ena restored.
   - Response: both outputs 0 on the next cycle each time. On re-enable, a full dead_act+1 low period occurs before either side asserts.
6. Random stress.
   - Stimulus: 10k cycles of random tri_q, cfg_wr and ena; async rst_n pulsed mid-run.
   - Response: assertion that pwm_hi and pwm_lo are never both 1 holds throughout. Outputs return to 0 immediately on rst_n falling.
